imem_ctrl: RTL

Sequencing controller for the single-port instruction memory array. It shares the array between the fetch stage (reads) and a boot/debug loader (writes) that streams a program image in. While a load is in progress it stalls fetch. In steady state it turns byte fetch addresses into word indices and returns the fetched word registered, one cycle later.

---
 rtl/imem_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - instruction memory fetch/load sequencer; IMEM_CTRL_CLEAR_EN adds a NOP-fill pass before each load
module imem_ctrl #(
    parameter int          DEPTH    = 1024,
    parameter int          AW       = 10,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_fetch_req,
    input  logic [31:0]   i_fetch_addr,
    output logic          o_fetch_valid,
    output logic [31:0]   o_fetch_data,
    output logic          o_fetch_misalign,
    output logic          o_fetch_stall,
    input  logic          i_ld_start,
    input  logic [AW-1:0] i_ld_base,
    input  logic [AW:0]   i_ld_count,
    input  logic          i_ld_valid,
    input  logic [31:0]   i_ld_data,
    output logic          o_ld_ready,
    output logic          o_ld_done,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata
);

`ifdef IMEM_CTRL_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state, state_nx;
    logic [AW-1:0] base, base_nx;
    logic [AW:0]   count, count_nx;
    logic [AW-1:0] n, n_nx;
    logic          misaligned;
    logic          unused_bits;

    assign misaligned    = (i_fetch_addr[1:0] != 2'b00);
    assign o_fetch_stall = (state != S_IDLE);
    assign unused_bits   = ^{i_fetch_addr[31:AW+2], LAST_IDX};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= S_IDLE;
            base             <= '0;
            count            <= '0;
            n                <= '0;
            o_fetch_valid    <= 1'b0;
            o_fetch_data     <= '0;
            o_fetch_misalign <= 1'b0;
        end else begin
            state <= state_nx;
            base  <= base_nx;
            count <= count_nx;
            n     <= n_nx;
            // Fetch is only serviced in IDLE; data and misalign hold when idle-without-request
            if (state == S_IDLE && i_fetch_req) begin
                o_fetch_valid <= 1'b1;
                if (misaligned) begin
                    o_fetch_data     <= '0;
                    o_fetch_misalign <= 1'b1;
                end else begin
                    o_fetch_data     <= i_mem_rdata;
                    o_fetch_misalign <= 1'b0;
                end
            end else begin
                o_fetch_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        base_nx     = base;
        count_nx    = count;
        n_nx        = n;
        o_mem_addr  = i_fetch_addr[AW+1:2];
        o_mem_we    = 1'b0;
        o_mem_wdata = NOP_WORD;
        o_ld_ready  = 1'b0;
        o_ld_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_ld_start) begin
                    base_nx  = i_ld_base;
                    count_nx = i_ld_count;
                    n_nx     = '0;
                    if (i_ld_count == '0)
                        state_nx = S_DONE;
                    else
`ifdef IMEM_CTRL_CLEAR_EN
                        state_nx = S_CLEAR;
`else
                        state_nx = S_LOAD;
`endif
                end
            end
`ifdef IMEM_CTRL_CLEAR_EN
            S_CLEAR: begin
                o_mem_addr = n;
                o_mem_we   = 1'b1;
                n_nx       = n + 1'b1;
                // n wraps to 0 on the last index, ready for LOAD
                if (n == LAST_IDX)
                    state_nx = S_LOAD;
            end
`endif
            S_LOAD: begin
                o_ld_ready = 1'b1;
                o_mem_addr = base + n;
                if (i_ld_valid) begin
                    o_mem_we    = 1'b1;
                    o_mem_wdata = i_ld_data;
                    n_nx        = n + 1'b1;
                    if ({1'b0, n} == count - (AW+1)'(1))
                        state_nx = S_DONE;
                end
            end
            S_DONE: begin
                o_ld_done = 1'b1;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
